iter_multiplier: RTL and testbench

//  Multi-cycle 32x32->64 integer multiplier; responder side of the execute-stage

---
 rtl/iter_multiplier_pkg.sv | 15 +
 rtl/iter_multiplier.sv | 106 ++++++++++
 tb/tb_iter_multiplier.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/iter_multiplier_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding and default latency,
// so execute/hazard logic can reference the multiply stall length.
package iter_multiplier_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_STEP_BITS = 2;
    localparam int MUL_CYCLES    = DEF_WIDTH / DEF_STEP_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_multiplier.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier for MUL/MUH/MULU/MUHU; retires STEP_BITS
// multiplier bits per BUSY cycle on magnitudes, then applies the sign on the final step.
module iter_multiplier
    import iter_multiplier_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STEP_BITS = DEF_STEP_BITS
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 is_unsign,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    localparam int N     = WIDTH / STEP_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     mcand_mag;
    logic [WIDTH-1:0]     mplier_mag;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   step_sum;
    logic                 last_step;

    // Magnitude of the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign a_mag = (!is_unsign && a[WIDTH-1]) ? -a : a;
    assign b_mag = (!is_unsign && b[WIDTH-1]) ? -b : b;

    assign last_step = (count == CNT_W'(N - 1));

    always_comb begin
        partial  = {{WIDTH{1'b0}}, mcand_mag}
                 * {{(2*WIDTH-STEP_BITS){1'b0}}, mplier_mag[STEP_BITS-1:0]};
        step_sum = acc + (partial << (STEP_BITS * int'(count)));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: defaults first so every path assigns next_state and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = BUSY;
            BUSY: begin
                if (!enable)        next_state = IDLE;
                else if (last_step) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            done       <= 1'b0;
            result     <= '0;
            acc        <= '0;
            count      <= '0;
            mcand_mag  <= '0;
            mplier_mag <= '0;
            neg        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        mcand_mag  <= a_mag;
                        mplier_mag <= b_mag;
                        neg        <= ~is_unsign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc        <= '0;
                        count      <= '0;
                    end
                end
                BUSY: begin
                    // A dropped enable is a pipeline flush: abandon without touching result.
                    if (enable) begin
                        acc        <= step_sum;
                        mplier_mag <= mplier_mag >> STEP_BITS;
                        count      <= count + CNT_W'(1);
                        if (last_step) begin
                            result <= neg ? -step_sum : step_sum;
                            done   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench: directed handshake/timing cases on the default DUT plus a random
// signed/unsigned sweep on STEP_BITS = 1, 2 and 4 instances against a 64-bit reference.
module tb_iter_multiplier;
    import iter_multiplier_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [2:0]  en;
    logic        is_unsign;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res [3];
    logic [2:0]  dn;

    int passed = 0;
    int total  = 0;
    logic [63:0] sb [$];

    always #5 sys_clk = ~sys_clk;

    iter_multiplier #(.WIDTH(32), .STEP_BITS(1)) u_s1 (
        .sys_clk(sys_clk), .rst(rst), .enable(en[0]), .is_unsign(is_unsign),
        .a(a), .b(b), .result(res[0]), .done(dn[0]));
    iter_multiplier #(.WIDTH(32), .STEP_BITS(2)) u_s2 (
        .sys_clk(sys_clk), .rst(rst), .enable(en[1]), .is_unsign(is_unsign),
        .a(a), .b(b), .result(res[1]), .done(dn[1]));
    iter_multiplier #(.WIDTH(32), .STEP_BITS(4)) u_s4 (
        .sys_clk(sys_clk), .rst(rst), .enable(en[2]), .is_unsign(is_unsign),
        .a(a), .b(b), .result(res[2]), .done(dn[2]));

    function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y, logic u);
        logic signed [63:0] sx, sy;
        if (u) return {32'd0, x} * {32'd0, y};
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        return 64'(sx * sy);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic start(input int k, input logic [31:0] x, input logic [31:0] y,
                         input logic u, input logic [63:0] exp);
        a = x;
        b = y;
        is_unsign = u;
        en[k] = 1'b1;
        sb.push_back(exp);
    endtask

    // Waits (bounded) for done from instance k; checks latency and pops the scoreboard.
    task automatic wait_done(input int k, input int lat, input string tag, input bit churn);
        int n = 0;
        do begin
            tick();
            n++;
            if (churn && !dn[k]) begin
                a = $urandom;
                b = $urandom;
                is_unsign = 1'($urandom_range(0, 1));
            end
        end while (!dn[k] && n < lat + 8);
        check({tag, " latency"}, 64'(n), 64'(lat));
        if (dn[k]) begin
            check({tag, " pending"}, 64'(sb.size()), 64'd1);
            if (sb.size() > 0) check({tag, " result"}, res[k], sb.pop_front());
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic finish_op(input int k, input string tag);
        en[k] = 1'b0;
        tick();
        check({tag, " done_low"}, 64'(dn[k]), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat [3];
        bit   saw;
        logic [31:0] x, y;
        logic u;
        lat[0] = 33;
        lat[1] = MUL_CYCLES + 1;
        lat[2] = 9;

        rst = 1'b1; en = 3'b000; is_unsign = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        check("reset done", 64'(dn[1]), 64'd0);
        check("reset result", res[1], 64'd0);
        rst = 1'b0;
        tick();

        // Unsigned extreme, signed corner cases.
        start(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_done(1, 17, "umax", 1'b0);
        finish_op(1, "umax");
        start(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(1, 17, "m1x1", 1'b0);
        finish_op(1, "m1x1");
        start(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        wait_done(1, 17, "minxmin", 1'b0);
        finish_op(1, "minxmin");
        start(1, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 64'h0);
        wait_done(1, 17, "m7x0", 1'b0);
        finish_op(1, "m7x0");

        // Back-to-back with enable held high.
        start(1, 32'd3, 32'd5, 1'b0, 64'd15);
        wait_done(1, 17, "b2b_first", 1'b0);
        start(1, 32'hFFFF_FFFE, 32'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF4);
        tick();
        check("b2b cycle18 done", 64'(dn[1]), 64'd0);
        wait_done(1, 17, "b2b_second", 1'b0);
        finish_op(1, "b2b_second");

        // Flush: enable dropped for cycles 8 and 9, re-raised at cycle 10 with new operands.
        a = 32'd11; b = 32'd13; is_unsign = 1'b0; en[1] = 1'b1;
        saw = 1'b0;
        repeat (8) begin tick(); saw |= dn[1]; end
        en[1] = 1'b0;
        repeat (2) begin tick(); saw |= dn[1]; end
        check("flush no_done", 64'(saw), 64'd0);
        check("flush result_kept", res[1], 64'hFFFF_FFFF_FFFF_FFF4);
        start(1, 32'd100, 32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FED4);
        wait_done(1, 17, "flush_new", 1'b0);
        finish_op(1, "flush_new");

        // Reset at BUSY cycle 5 discards the op.
        a = 32'd123; b = 32'd456; is_unsign = 1'b1; en[1] = 1'b1;
        repeat (5) tick();
        rst = 1'b1; en[1] = 1'b0;
        tick();
        check("midrst done", 64'(dn[1]), 64'd0);
        check("midrst result", res[1], 64'd0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin tick(); saw |= dn[1]; end
        check("midrst no_done", 64'(saw), 64'd0);
        start(1, 32'd9, 32'd9, 1'b1, 64'd81);
        wait_done(1, 17, "after_rst", 1'b0);
        finish_op(1, "after_rst");

        // Operands churn every BUSY cycle; result uses cycle-0 values.
        start(1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0,
              ref_mul(32'hDEAD_BEEF, 32'h1234_5678, 1'b0));
        wait_done(1, 17, "churn", 1'b1);
        finish_op(1, "churn");

        // Random sweep on all step widths.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                x = pick();
                y = pick();
                u = 1'($urandom_range(0, 1));
                start(k, x, y, u, ref_mul(x, y, u));
                wait_done(k, lat[k], $sformatf("sweep s%0d #%0d", k, i), 1'b0);
                finish_op(k, $sformatf("sweep s%0d #%0d", k, i));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
